timer_bank: RTL and testbench

Parametrised bank of N_CH independent down-counting timers sharing one system clock, each advanced by a per-channel synchronous tick enable instead of its own clock. Each channel has one-shot, periodic, square-wave and free-run modes, a reload register, a level output and a sticky expiry flag. A small register file (reload, control, status) is written and read by the bus-side logic. This block is the generalised successor of the fixed 3-channel counter and replaces it in new designs.

---
 rtl/timer_bank_pkg.sv | 29 ++
 rtl/timer_bank_if.sv | 34 +++
 rtl/timer_bank_channel.sv | 128 ++++++++++++
 rtl/timer_bank.sv | 142 ++++++++++++++
 tb/tb_timer_bank.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_bank_pkg.sv
// timer_bank_pkg: shared types and constants for the timer bank.
//   - mode_e: per-channel counting mode.
//   - Control field offsets inside each channel's 4-bit control nibble.
//   - Helpers for the control and status register addresses.
package timer_bank_pkg;

  typedef enum logic [1:0] {
    MODE_ONESHOT  = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_SQUARE   = 2'b10,
    MODE_FREERUN  = 2'b11
  } mode_e;

  localparam int MODE_LSB    = 0;
  localparam int EN_BIT      = 2;
  localparam int IE_BIT      = 3;
  localparam int CTRL_STRIDE = 4;

  // Control register sits directly after the channel registers.
  function automatic int ctrl_addr(input int n_ch);
    return n_ch;
  endfunction

  // Status register follows the control register.
  function automatic int status_addr(input int n_ch);
    return n_ch + 1;
  endfunction

endpackage

// File: rtl/timer_bank_if.sv
// timer_bank_if: bus and timer I/O bundle for timer_bank.
//   tick   [N_CH]  per-channel count enable
//   we             register write strobe
//   addr   [AW]    register select (channels, control, status)
//   wdata  [WIDTH] write data
//   rdata  [WIDTH] read data (combinational from addr)
//   ch_out [N_CH]  per-channel timer output
//   irq            interrupt request
// master drives stimulus/bus side, slave is the timer bank.
interface timer_bank_if #(
  parameter int N_CH  = 3,
  parameter int WIDTH = 32
);
  localparam int AW = $clog2(N_CH + 2);

  logic [N_CH-1:0]  tick;
  logic             we;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic [N_CH-1:0]  ch_out;
  logic             irq;

  modport master (
    output tick, we, addr, wdata,
    input  rdata, ch_out, irq
  );

  modport slave (
    input  tick, we, addr, wdata,
    output rdata, ch_out, irq
  );

endinterface

// File: rtl/timer_bank_channel.sv
// timer_channel: one down-counting timer of the bank.
//   clk, rst  system clock, async active-high reset
//   tick, en  count only when both are high
//   mode      counting mode (one-shot, periodic, square, free-run)
//   wr, wdata load reload and count (a write beats a same-cycle tick)
//   count     current count value
//   ch_out    registered timer output
//   expire    high in the cycle whose clock edge performs an expiry event
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             en,
  input  mode_e            mode,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] count,
  output logic             ch_out,
  output logic             expire
);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] reload_r;
  logic             ch_out_r;
  logic [WIDTH-1:0] count_nx;
  logic [WIDTH-1:0] reload_nx;
  logic             ch_out_nx;
  logic             expire_s;
  logic [WIDTH-1:0] dec_s;
  logic             at_zero_s;

  assign dec_s     = count_r - WIDTH'(1);
  assign at_zero_s = (count_r == '0);

  // Next-state computation for count, reload and output.
  always_comb begin
    count_nx  = count_r;
    reload_nx = reload_r;
    expire_s  = 1'b0;
    // The periodic pulse lasts exactly one clk cycle, independent of ticks.
    if (mode == MODE_PERIODIC) begin
      ch_out_nx = 1'b0;
    end else begin
      ch_out_nx = ch_out_r;
    end

    if (wr) begin
      reload_nx = wdata;
      if (mode == MODE_SQUARE) begin
        count_nx = {1'b0, wdata[WIDTH-1:1]};
      end else begin
        count_nx = wdata;
      end
      // In free-run the output always mirrors the count MSB.
      if (mode == MODE_FREERUN) begin
        ch_out_nx = wdata[WIDTH-1];
      end else begin
        ch_out_nx = 1'b0;
      end
    end else if (en && tick) begin
      case (mode)
        MODE_ONESHOT: begin
          if (!at_zero_s) begin
            count_nx = dec_s;
            if (count_r == WIDTH'(1)) begin
              ch_out_nx = 1'b1;
              expire_s  = 1'b1;
            end else begin
              ch_out_nx = ch_out_r;
            end
          end else begin
            count_nx = count_r;
          end
        end
        MODE_PERIODIC: begin
          if (!at_zero_s) begin
            count_nx = dec_s;
          end else begin
            count_nx  = reload_r;
            ch_out_nx = 1'b1;
            expire_s  = 1'b1;
          end
        end
        MODE_SQUARE: begin
          if (!at_zero_s) begin
            count_nx = dec_s;
          end else begin
            count_nx  = {1'b0, reload_r[WIDTH-1:1]};
            ch_out_nx = ~ch_out_r;
            expire_s  = 1'b1;
          end
        end
        MODE_FREERUN: begin
          count_nx  = dec_s;
          ch_out_nx = dec_s[WIDTH-1];
          expire_s  = at_zero_s;
        end
        default: begin
          count_nx = count_r;
        end
      endcase
    end else begin
      count_nx = count_r;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r  <= '0;
      reload_r <= '0;
      ch_out_r <= 1'b0;
    end else begin
      count_r  <= count_nx;
      reload_r <= reload_nx;
      ch_out_r <= ch_out_nx;
    end
  end

  assign count  = count_r;
  assign ch_out = ch_out_r;
  assign expire = expire_s;

endmodule

// File: rtl/timer_bank.sv
// timer_bank: N_CH independent down-counting timers with a small register file.
//   clk, rst  system clock, async active-high reset
//   bus       timer_bank_if.slave: tick, we, addr, wdata, rdata, ch_out, irq
// Register map: 0..N_CH-1 channel reload/count, N_CH control, N_CH+1 status (W1C).
// Optional feature macro TIMER_BANK_IRQ_EN: when defined the ie bits are
// writable and irq = registered OR of (flag & ie); otherwise irq is held at 0
// and the ie bits read 0.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int N_CH  = 3,
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  timer_bank_if.slave   bus
);

  localparam int AW     = $clog2(N_CH + 2);
  localparam int CW     = CTRL_STRIDE * N_CH;
  localparam int CTRL_A = ctrl_addr(N_CH);
  localparam int STAT_A = status_addr(N_CH);

`ifdef TIMER_BANK_IRQ_EN
  localparam logic IE_WRITABLE = 1'b1;
`else
  localparam logic IE_WRITABLE = 1'b0;
`endif

  // Writable control bits: mode and en always, ie only with interrupts built in.
  function automatic logic [CW-1:0] ctrl_mask(input logic ie_writable);
    logic [CW-1:0] m;
    m = '0;
    for (int i = 0; i < N_CH; i++) begin
      m[i*CTRL_STRIDE + MODE_LSB +: 2] = 2'b11;
      m[i*CTRL_STRIDE + EN_BIT]        = 1'b1;
      m[i*CTRL_STRIDE + IE_BIT]        = ie_writable;
    end
    return m;
  endfunction

  localparam logic [CW-1:0] CTRL_MASK = ctrl_mask(IE_WRITABLE);

  logic [CW-1:0]    ctrl_r;
  logic [N_CH-1:0]  flags_r;
  logic             irq_r;
  logic [N_CH-1:0]  flags_nx;
  logic             irq_nx;
  logic             ctrl_wr_s;
  logic             stat_wr_s;
  logic [N_CH-1:0]  ch_wr_s;
  logic [N_CH-1:0]  en_s;
  logic [N_CH-1:0]  expire_s;
  mode_e            mode_s  [N_CH];
  logic [WIDTH-1:0] count_s [N_CH];
  logic [WIDTH-1:0] rdata_s;

  assign ctrl_wr_s = bus.we && (bus.addr == AW'(CTRL_A));
  assign stat_wr_s = bus.we && (bus.addr == AW'(STAT_A));

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign ch_wr_s[i] = bus.we && (bus.addr == AW'(i));
    assign en_s[i]    = ctrl_r[i*CTRL_STRIDE + EN_BIT];
    assign mode_s[i]  = mode_e'(ctrl_r[i*CTRL_STRIDE + MODE_LSB +: 2]);

    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .tick   (bus.tick[i]),
      .en     (en_s[i]),
      .mode   (mode_s[i]),
      .wr     (ch_wr_s[i]),
      .wdata  (bus.wdata),
      .count  (count_s[i]),
      .ch_out (bus.ch_out[i]),
      .expire (expire_s[i])
    );
  end

  // Status flags: write-1-to-clear, with a same-cycle expiry taking priority.
  always_comb begin
    flags_nx = flags_r;
    if (stat_wr_s) begin
      flags_nx = flags_r & ~bus.wdata[N_CH-1:0];
    end else begin
      flags_nx = flags_r;
    end
    flags_nx = flags_nx | expire_s;
  end

  // Interrupt request source, evaluated from the already-registered flags.
  always_comb begin
    irq_nx = 1'b0;
`ifdef TIMER_BANK_IRQ_EN
    for (int i = 0; i < N_CH; i++) begin
      if (flags_r[i] && ctrl_r[i*CTRL_STRIDE + IE_BIT]) begin
        irq_nx = 1'b1;
      end else begin
        irq_nx = irq_nx;
      end
    end
`endif
  end

  // Control, status and interrupt registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_r  <= '0;
      flags_r <= '0;
      irq_r   <= 1'b0;
    end else begin
      if (ctrl_wr_s) begin
        ctrl_r <= bus.wdata[CW-1:0] & CTRL_MASK;
      end
      flags_r <= flags_nx;
      irq_r   <= irq_nx;
    end
  end

  // Read mux: channel addresses return the live count, not the reload value.
  always_comb begin
    rdata_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.addr == AW'(i)) begin
        rdata_s = count_s[i];
      end else begin
        rdata_s = rdata_s;
      end
    end
    if (bus.addr == AW'(CTRL_A)) begin
      rdata_s = WIDTH'(ctrl_r);
    end else if (bus.addr == AW'(STAT_A)) begin
      rdata_s = WIDTH'(flags_r);
    end else begin
      rdata_s = rdata_s;
    end
  end

  assign bus.rdata = rdata_s;
  assign bus.irq   = irq_r;

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed self-checking bench for timer_bank (N_CH=3, WIDTH=32).
module tb_timer_bank;

  localparam int N_CH  = 3;
  localparam int WIDTH = 32;
  localparam logic [2:0] A_CTRL = 3'd3;
  localparam logic [2:0] A_STAT = 3'd4;

`ifdef TIMER_BANK_IRQ_EN
  localparam logic        EXP_IRQ    = 1'b1;
  localparam logic [31:0] EXP_CTRL_C = 32'hC;
`else
  localparam logic        EXP_IRQ    = 1'b0;
  localparam logic [31:0] EXP_CTRL_C = 32'h4;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  timer_bank_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();

  timer_bank #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    step();
    bus.we    = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.we   = 1'b0;
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    bus.tick = '0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    #3;
    for (int a = 0; a < 5; a++) begin
      rd(3'(a), d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL reset_rdata a=%0d got=%0h exp=0", a, d); end
    end
    total++;
    if (bus.ch_out !== 3'b000) begin bad++; $display("FAIL reset_ch_out got=%b exp=000", bus.ch_out); end
    total++;
    if (bus.irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end
    #2;
    rst = 1'b0;
    step();
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    wr(3'd0, 32'd5);
    wr(A_CTRL, 32'h4);
    bus.tick = 3'b001;
    for (int k = 1; k <= 15; k++) begin
      step();
      total++;
      if (bus.ch_out[0] !== (k >= 5)) begin bad++; $display("FAIL oneshot_out k=%0d got=%b exp=%b", k, bus.ch_out[0], (k >= 5)); end
      rd(3'd0, d);
      total++;
      if (d !== ((k < 5) ? 32'(5 - k) : 32'd0)) begin bad++; $display("FAIL oneshot_count k=%0d got=%0h", k, d); end
      if (k == 5) begin
        rd(A_STAT, d);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL oneshot_status got=%0h exp=1", d); end
      end
    end
    bus.tick = 3'b000;
    wr(A_STAT, 32'h1);
    rd(A_STAT, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL oneshot_clear got=%0h exp=0", d); end
  endtask

  task automatic test_periodic();
    logic [31:0] d;
    int c;
    logic pulse;
    wr(A_CTRL, 32'h50);
    wr(3'd1, 32'd3);
    c = 3;
    bus.tick = 3'b010;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (c > 0) begin c--; pulse = 1'b0; end else begin c = 3; pulse = 1'b1; end
      total++;
      if (bus.ch_out[1] !== pulse) begin bad++; $display("FAIL periodic_out k=%0d got=%b exp=%b", k, bus.ch_out[1], pulse); end
      rd(3'd1, d);
      total++;
      if (d !== 32'(c)) begin bad++; $display("FAIL periodic_count k=%0d got=%0h exp=%0h", k, d, c); end
    end
    bus.tick = 3'b000;
    rd(A_STAT, d);
    total++;
    if (d !== 32'h2) begin bad++; $display("FAIL periodic_status got=%0h exp=2", d); end
    wr(A_STAT, 32'h2);
    rd(A_STAT, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL periodic_clear got=%0h exp=0", d); end
    bus.tick = 3'b010;
    step(); step(); step();
    // Count is now 0: the next tick expires while status is being cleared.
    bus.we = 1'b1; bus.addr = A_STAT; bus.wdata = 32'h2;
    step();
    bus.we = 1'b0; bus.tick = 3'b000;
    total++;
    if (bus.ch_out[1] !== 1'b1) begin bad++; $display("FAIL periodic_coinc_out got=%b exp=1", bus.ch_out[1]); end
    rd(A_STAT, d);
    total++;
    if (d !== 32'h2) begin bad++; $display("FAIL periodic_set_wins got=%0h exp=2", d); end
  endtask

  task automatic test_square();
    logic [31:0] d;
    wr(A_CTRL, 32'h600);
    wr(3'd2, 32'd8);
    rd(3'd2, d);
    total++;
    if (d !== 32'd4) begin bad++; $display("FAIL square_load got=%0h exp=4", d); end
    bus.tick = 3'b100;
    for (int k = 1; k <= 15; k++) begin
      step();
      total++;
      if (bus.ch_out[2] !== 1'((k / 5) % 2)) begin bad++; $display("FAIL square_out k=%0d got=%b", k, bus.ch_out[2]); end
    end
    bus.tick = 3'b000;
    wr(3'd2, 32'd1);
    total++;
    if (bus.ch_out[2] !== 1'b0) begin bad++; $display("FAIL square_wr_clear got=%b exp=0", bus.ch_out[2]); end
    bus.tick = 3'b100;
    for (int k = 1; k <= 4; k++) begin
      step();
      total++;
      if (bus.ch_out[2] !== 1'(k % 2)) begin bad++; $display("FAIL square_fast k=%0d got=%b", k, bus.ch_out[2]); end
    end
    bus.tick = 3'b000;
  endtask

  task automatic test_freerun_enable();
    logic [31:0] d;
    wr(A_STAT, 32'h7);
    wr(A_CTRL, 32'h7);
    wr(3'd0, 32'd0);
    bus.tick = 3'b001;
    step();
    bus.tick = 3'b000;
    rd(3'd0, d);
    total++;
    if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL freerun_wrap got=%0h exp=ffffffff", d); end
    total++;
    if (bus.ch_out[0] !== 1'b1) begin bad++; $display("FAIL freerun_out got=%b exp=1", bus.ch_out[0]); end
    rd(A_STAT, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL freerun_flag got=%0h exp=1", d); end
    bus.tick = 3'b001;
    step(); step();
    bus.tick = 3'b000;
    rd(3'd0, d);
    total++;
    if (d !== 32'hFFFF_FFFD) begin bad++; $display("FAIL freerun_dec got=%0h exp=fffffffd", d); end
    wr(A_CTRL, 32'h3);
    bus.tick = 3'b001;
    for (int k = 0; k < 5; k++) step();
    bus.tick = 3'b000;
    rd(3'd0, d);
    total++;
    if (d !== 32'hFFFF_FFFD) begin bad++; $display("FAIL disabled_freeze got=%0h exp=fffffffd", d); end
    total++;
    if (bus.ch_out[0] !== 1'b1) begin bad++; $display("FAIL disabled_hold got=%b exp=1", bus.ch_out[0]); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    wr(A_CTRL, 32'h4);
    bus.we = 1'b1; bus.addr = 3'd0; bus.wdata = 32'd10; bus.tick = 3'b001;
    step();
    bus.we = 1'b0; bus.tick = 3'b000;
    rd(3'd0, d);
    total++;
    if (d !== 32'd10) begin bad++; $display("FAIL collision_write got=%0h exp=a", d); end
    bus.tick = 3'b001;
    step();
    bus.tick = 3'b000;
    wr(3'd5, 32'hFFFF_FFFF);
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd0, d);
    total++;
    if (d !== 32'd9) begin bad++; $display("FAIL collision_tick got=%0h exp=9", d); end
    rd(A_CTRL, d);
    total++;
    if (d !== 32'h4) begin bad++; $display("FAIL unmapped_ctrl got=%0h exp=4", d); end
    rd(A_STAT, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL unmapped_stat got=%0h exp=1", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    wr(A_STAT, 32'h7);
    wr(A_CTRL, 32'hC);
    wr(3'd0, 32'd1);
    total++;
    if (bus.irq !== 1'b0) begin bad++; $display("FAIL irq_idle got=%b exp=0", bus.irq); end
    bus.tick = 3'b001;
    step();
    bus.tick = 3'b000;
    total++;
    if (bus.irq !== 1'b0) begin bad++; $display("FAIL irq_early got=%b exp=0", bus.irq); end
    step();
    total++;
    if (bus.irq !== EXP_IRQ) begin bad++; $display("FAIL irq_assert got=%b exp=%b", bus.irq, EXP_IRQ); end
    rd(A_CTRL, d);
    total++;
    if (d !== EXP_CTRL_C) begin bad++; $display("FAIL irq_ie_read got=%0h exp=%0h", d, EXP_CTRL_C); end
    wr(A_STAT, 32'h1);
    step();
    total++;
    if (bus.irq !== 1'b0) begin bad++; $display("FAIL irq_release got=%b exp=0", bus.irq); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(A_CTRL, 32'h604);
    wr(3'd0, 32'd50);
    wr(3'd2, 32'd1);
    bus.tick = 3'b101;
    step(); step(); step();
    total++;
    if (bus.ch_out[2] !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b exp=1", bus.ch_out[2]); end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.ch_out !== 3'b000) begin bad++; $display("FAIL midrst_out got=%b exp=000", bus.ch_out); end
    total++;
    if (bus.irq !== 1'b0) begin bad++; $display("FAIL midrst_irq got=%b exp=0", bus.irq); end
    for (int a = 0; a < 5; a++) begin
      rd(3'(a), d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL midrst_rdata a=%0d got=%0h exp=0", a, d); end
    end
    step();
    total++;
    if (bus.ch_out !== 3'b000) begin bad++; $display("FAIL midrst_hold got=%b exp=000", bus.ch_out); end
    bus.tick = 3'b000;
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_square();
    test_freerun_enable();
    test_collision();
    test_irq();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
